// File: rtl/burst_writer.sv
// burst_writer: buffers upstream words and emits them as fixed-length bursts.
// Optional partial-burst flush is enabled with BURST_WRITER_FLUSH_EN.
module burst_writer #(
   parameter int WDTH              = 32,
   parameter int BUFFER_LENGTH     = 16,
   parameter int LOG_BUFFER_LENGTH = 4,
   parameter int BURST_LENGTH      = 4,
   parameter int LOG_BURST_LENGTH  = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [WDTH-1:0] in_data,
   input  logic            in_nd,
   input  logic            downstream_ready,
`ifdef BURST_WRITER_FLUSH_EN
   input  logic            flush,
`endif
   output logic [WDTH-1:0] out_data,
   output logic            out_nd,
   output logic            overflow_error,
   output logic            busy
);

   localparam int PW = LOG_BUFFER_LENGTH;
   localparam int CW = LOG_BUFFER_LENGTH + 1;
   localparam int BW = LOG_BURST_LENGTH;
   localparam logic [CW-1:0] FULL_C = CW'(BUFFER_LENGTH);
   localparam logic [CW-1:0] BL_C   = CW'(BURST_LENGTH);
   localparam logic [BW-1:0] LAST_C = BW'(BURST_LENGTH - 1);

`ifdef BURST_WRITER_FLUSH_EN
   typedef enum logic [1:0] {S_IDLE, S_BURST, S_FLUSH} state_t;
`else
   typedef enum logic {S_IDLE, S_BURST} state_t;
`endif

   logic [WDTH-1:0] mem_q [BUFFER_LENGTH];
   logic [PW-1:0]   wr_ptr_q;
   logic [PW-1:0]   rd_ptr_q;
   logic [CW-1:0]   count_q;
   logic [CW-1:0]   count_d;
   logic [BW-1:0]   burst_cnt_q;
   state_t          state_q;
   logic [WDTH-1:0] out_data_q;
   logic            out_nd_q;
   logic            ovf_q;
   logic            busy_q;

   logic            full_w;
   logic            start_w;
   logic            pop_w;
   logic            push_w;
`ifdef BURST_WRITER_FLUSH_EN
   logic            flush_go_w;
   logic [BW-1:0]   left_q;
`endif

   // Start/pop/push decisions; a new transfer waits for one idle out_nd cycle.
   always_comb begin
      full_w  = (count_q == FULL_C);
      start_w = (state_q == S_IDLE) && !out_nd_q
                && (count_q >= BL_C) && downstream_ready;
`ifdef BURST_WRITER_FLUSH_EN
      flush_go_w = (state_q == S_IDLE) && !out_nd_q && flush
                   && (count_q != '0) && (count_q < BL_C)
                   && downstream_ready;
      pop_w = start_w || flush_go_w
              || (state_q == S_BURST) || (state_q == S_FLUSH);
`else
      pop_w = start_w || (state_q == S_BURST);
`endif
      push_w  = in_nd && (!full_w || pop_w);
      count_d = count_q;
      unique case ({push_w, pop_w})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage array; stale contents are harmless since pointers reset.
   always_ff @(posedge clk) begin
      if (push_w) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   // Circular buffer pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_w) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_w)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_d;
      end
   end

   // Transfer FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         burst_cnt_q <= '0;
         out_data_q  <= '0;
         out_nd_q    <= 1'b0;
         ovf_q       <= 1'b0;
         busy_q      <= 1'b0;
`ifdef BURST_WRITER_FLUSH_EN
         left_q      <= '0;
`endif
      end else begin
         out_nd_q <= pop_w;
         busy_q   <= pop_w;
         ovf_q    <= in_nd && full_w && !pop_w;
         if (pop_w) out_data_q <= mem_q[rd_ptr_q];
         unique case (state_q)
            S_IDLE: begin
               if (start_w) begin
                  state_q     <= S_BURST;
                  burst_cnt_q <= BW'(1);
               end
`ifdef BURST_WRITER_FLUSH_EN
               else if (flush_go_w) begin
                  left_q  <= BW'(count_q - CW'(1));
                  state_q <= (count_q == CW'(1)) ? S_IDLE : S_FLUSH;
               end
`endif
            end
            S_BURST: begin
               burst_cnt_q <= burst_cnt_q + BW'(1);
               if (burst_cnt_q == LAST_C) state_q <= S_IDLE;
            end
`ifdef BURST_WRITER_FLUSH_EN
            S_FLUSH: begin
               left_q <= left_q - BW'(1);
               if (left_q == BW'(1)) state_q <= S_IDLE;
            end
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign out_data       = out_data_q;
   assign out_nd         = out_nd_q;
   assign overflow_error = ovf_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_burst_writer.sv
// Directed bench for burst_writer: queue-based reference model checked
// every cycle, plus literal expectations on the emitted word streams.
module tb_burst_writer;

   localparam int DEPTH = 16;
   localparam int BURST = 4;

   logic        clk;
   logic        rst_n;
   logic [31:0] in_data;
   logic        in_nd;
   logic        downstream_ready;
`ifdef BURST_WRITER_FLUSH_EN
   logic        flush;
`endif
   logic [31:0] out_data;
   logic        out_nd;
   logic        overflow_error;
   logic        busy;

   burst_writer dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .in_data          (in_data),
      .in_nd            (in_nd),
      .downstream_ready (downstream_ready),
`ifdef BURST_WRITER_FLUSH_EN
      .flush            (flush),
`endif
      .out_data         (out_data),
      .out_nd           (out_nd),
      .overflow_error   (overflow_error),
      .busy             (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // reference model state
   logic [31:0] mq[$];
   int          left = 0;
   logic        e_nd = 1'b0;
   logic [31:0] e_data = '0;
   logic        e_ovf = 1'b0;
   logic        e_busy = 1'b0;
   bit          started = 0;

   // observed stream
   logic [31:0] got[$];
   int          ovf_cnt = 0;
   int          rises = 0;
   int          bcnt = 0;
   logic        prev_nd = 1'b0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Model: a FIFO of stored words, a remaining-words-in-transfer count,
   // and the rule that a transfer may begin only after an idle output cycle.
   always @(posedge clk) begin
      bit pop;
      bit full;
      started = 1;
      if (!rst_n) begin
         mq.delete();
         left   = 0;
         e_nd   = 1'b0;
         e_data = '0;
         e_ovf  = 1'b0;
         e_busy = 1'b0;
      end else begin
         pop = 0;
         if (left > 0) pop = 1;
         else if (!e_nd && downstream_ready && mq.size() >= BURST) begin
            left = BURST;
            pop  = 1;
         end
`ifdef BURST_WRITER_FLUSH_EN
         else if (!e_nd && downstream_ready && flush && mq.size() > 0) begin
            left = mq.size();
            pop  = 1;
         end
`endif
         full  = (mq.size() == DEPTH);
         e_ovf = in_nd && full && !pop;
         if (pop) begin
            e_data = mq.pop_front();
            left--;
         end
         if (in_nd && (!full || pop)) mq.push_back(in_data);
         e_nd   = pop;
         e_busy = pop;
      end
   end

   // Per-cycle comparison against the model, plus stream capture.
   always @(negedge clk) begin
      if (started) begin
         check("out_nd", {31'b0, out_nd}, {31'b0, e_nd});
         check("out_data", out_data, e_data);
         check("overflow_error", {31'b0, overflow_error}, {31'b0, e_ovf});
         check("busy", {31'b0, busy}, {31'b0, e_busy});
         if (out_nd === 1'b1) got.push_back(out_data);
         if (overflow_error === 1'b1) ovf_cnt++;
         if (busy === 1'b1) bcnt++;
         if (out_nd === 1'b1 && prev_nd !== 1'b1) rises++;
         prev_nd = out_nd;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_nd = 1'b0;
      downstream_ready = 1'b0;
      tick(2);
      got.delete();
      ovf_cnt = 0;
      rises   = 0;
      bcnt    = 0;
      rst_n   = 1'b1;
   endtask

   task automatic write(input logic [31:0] w);
      in_data = w;
      in_nd   = 1'b1;
      @(negedge clk);
      in_nd   = 1'b0;
   endtask

   task automatic expect_seq(input string nm, input int base, input int n);
      check({nm, "_len"}, got.size(), n);
      for (int i = 0; i < n && i < got.size(); i++)
         check({nm, "_word"}, got[i], base + i);
   endtask

   initial begin
      bit seen;
      rst_n = 1'b0;
      in_nd = 1'b0;
      in_data = '0;
      downstream_ready = 1'b0;
`ifdef BURST_WRITER_FLUSH_EN
      flush = 1'b0;
`endif
      @(negedge clk);

      // reset values
      do_reset();
      check("rst_out_nd", {31'b0, out_nd}, 32'd0);
      check("rst_out_data", out_data, 32'd0);

      // one burst of 4 with ready high
      downstream_ready = 1'b1;
      for (int i = 1; i <= 4; i++) write(i);
      tick(10);
      expect_seq("s1", 1, 4);
      check("s1_busy_cycles", bcnt, 4);
      check("s1_rises", rises, 1);

      // 8 stored, then two separated bursts
      do_reset();
      for (int i = 0; i < 8; i++) write(32'h11 + i);
      downstream_ready = 1'b1;
      tick(25);
      expect_seq("s2", 32'h11, 8);
      check("s2_rises", rises, 2);

      // overflow on word 17
      do_reset();
      for (int i = 0; i < 17; i++) write(32'h21 + i);
      tick(1);
      check("s3_ovf_cnt", ovf_cnt, 1);
      check("s3_model_fill", mq.size(), 16);
      downstream_ready = 1'b1;
      tick(40);
      expect_seq("s3", 32'h21, 16);
      check("s3_ovf_total", ovf_cnt, 1);

      // full buffer, writes during a burst are accepted
      do_reset();
      for (int i = 0; i < 16; i++) write(32'h41 + i);
      downstream_ready = 1'b1;
      for (int i = 16; i < 20; i++) write(32'h41 + i);
      check("s4_model_fill", mq.size(), 16);
      tick(40);
      expect_seq("s4", 32'h41, 20);
      check("s4_ovf_cnt", ovf_cnt, 0);

      // reset in the middle of a burst
      do_reset();
      downstream_ready = 1'b1;
      for (int i = 0; i < 4; i++) write(32'h51 + i);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (out_nd === 1'b1) seen = 1;
      end
      check("s5_burst_seen", {31'b0, seen}, 32'd1);
      rst_n   = 1'b0;
      in_nd   = 1'b1;
      in_data = 32'h99;
      @(negedge clk);
      check("s5_abort_nd", {31'b0, out_nd}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      in_nd = 1'b0;
      got.delete();
      for (int i = 0; i < 3; i++) write(32'h61 + i);
      tick(15);
      expect_seq("s5", 32'h61, 0);

`ifdef BURST_WRITER_FLUSH_EN
      // partial burst flush
      do_reset();
      downstream_ready = 1'b1;
      write(32'hA);
      write(32'hB);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      tick(6);
      expect_seq("s6", 32'hA, 2);
      check("s6_model_empty", mq.size(), 0);
      got.delete();
      for (int i = 0; i < 4; i++) write(32'h71 + i);
      tick(10);
      expect_seq("s6b", 32'h71, 4);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/burst_writer.md
BURST_WRITER -- requirements
Module: burst_writer

Interface
REQ-001 SHALL have parameter WDTH, default 32, data word width.
REQ-002 SHALL have parameter BUFFER_LENGTH, default 16, internal storage depth in words.
REQ-003 SHALL have parameter LOG_BUFFER_LENGTH, default 4, log2(BUFFER_LENGTH).
REQ-004 SHALL have parameter BURST_LENGTH, default 4, words per burst, a power of two no greater than BUFFER_LENGTH.
REQ-005 SHALL have parameter LOG_BURST_LENGTH, default 2, log2(BURST_LENGTH).
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit, synchronous active-low reset.
REQ-008 SHALL have port in_data, input, WDTH bits, upstream word.
REQ-009 SHALL have port in_nd, input, 1 bit, in_data valid this cycle.
REQ-010 SHALL have port downstream_ready, input, 1 bit, downstream can absorb one complete burst.
REQ-011 SHALL have port out_data, output reg, WDTH bits, burst word.
REQ-012 SHALL have port out_nd, output reg, 1 bit, out_data valid.
REQ-013 SHALL have port overflow_error, output reg, 1 bit, one-cycle pulse when an input word is dropped.
REQ-014 SHALL have port busy, output reg, 1 bit, high while in state BURST.

Function
REQ-015 SHALL store accepted words in an internal circular buffer with LOG_BUFFER_LENGTH-bit read/write pointers wrapping modulo BUFFER_LENGTH and a count of 0..BUFFER_LENGTH.
REQ-016 SHALL accept in_data on in_nd when count < BUFFER_LENGTH, or when count == BUFFER_LENGTH and a word is popped in the same cycle.
REQ-017 SHALL drop the word and pulse overflow_error the following cycle when in_nd arrives while full with no simultaneous pop; buffer contents unchanged.
REQ-018 SHALL reflect an accepted word in count on the next cycle; simultaneous push and pop leaves count unchanged.
REQ-019 SHALL implement states IDLE and BURST.
REQ-020 SHALL move IDLE->BURST at an edge where count >= BURST_LENGTH and downstream_ready == 1, popping the head word on that same edge.
REQ-021 SHALL, in BURST, pop one word per edge, registering out_data = popped word and out_nd = 1, giving exactly BURST_LENGTH consecutive out_nd cycles in FIFO order.
REQ-022 SHALL track words emitted with a LOG_BURST_LENGTH-bit burst counter that wraps to 0 on the last word, returning to IDLE on that edge.
REQ-023 SHALL insert at least one out_nd-low cycle between bursts; downstream_ready is sampled only in IDLE, and deassertion mid-burst does not stop the burst.
REQ-024 SHALL hold out_data at its last value while out_nd is 0.
REQ-025 SHALL give first out_nd exactly 1 cycle after the edge on which the start condition is met.

Reset
REQ-026 SHALL, when rst_n == 0 at an edge, set state = IDLE, pointers, count and burst counter = 0, out_data = 0, out_nd = 0, overflow_error = 0, busy = 0.
REQ-027 SHALL abort a burst in progress on reset, discarding all stored words; in_nd during reset is ignored.

Configuration
REQ-028 SHALL, when macro BURST_WRITER_FLUSH_EN is defined, add port flush (input, 1 bit) and state FLUSH.
REQ-029 SHALL, with BURST_WRITER_FLUSH_EN, move IDLE->FLUSH at an edge with flush == 1, 0 < count < BURST_LENGTH and downstream_ready == 1, then emit the count words present at that edge consecutively, returning to IDLE; busy is high in FLUSH; words arriving during FLUSH are retained for later.
REQ-030 SHALL, with BURST_WRITER_FLUSH_EN, ignore flush when count == 0, when count >= BURST_LENGTH (a normal burst starts) or outside IDLE.
REQ-031 SHALL, without BURST_WRITER_FLUSH_EN, have no flush port and no FLUSH state; partial bursts wait indefinitely.

Verification
REQ-032 SHALL cover: reset, downstream_ready = 1, write 0x1..0x4 on consecutive cycles -> out_nd high 4 consecutive cycles carrying 0x1,0x2,0x3,0x4, busy high for those cycles.
REQ-033 SHALL cover: write 8 words with downstream_ready = 0, then raise it -> two bursts of 4 in order, separated by at least one out_nd-low cycle.
REQ-034 SHALL cover: downstream_ready = 0, write 17 words -> words 1..16 retained, one overflow_error pulse for word 17; later bursts contain words 1..16 only.
REQ-035 SHALL cover: buffer full with a burst in progress, in_nd asserted -> no overflow_error, word accepted, count unchanged that cycle.
REQ-036 SHALL cover: assert rst_n = 0 on the second word of a burst -> out_nd = 0 next cycle; after reset, 3 words written -> no output.
REQ-037 SHALL cover, with BURST_WRITER_FLUSH_EN: write 0xA,0xB, pulse flush with downstream_ready = 1 -> out_nd for 2 cycles with 0xA,0xB, then IDLE, count = 0.
